vga_dac_palette: RTL and testbench

VGA_DAC_PALETTE -- requirements
Module: vga_dac_palette

---
 rtl/vga_dac_pkg.sv | 43 ++++
 rtl/vga_dac_palette_if.sv | 39 +++
 rtl/vga_dac_ram.sv | 38 +++
 rtl/vga_dac_palette.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_dac_palette.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_dac_pkg.sv
// ---------------------------------------------------------------------------
// vga_dac_pkg
// Shared constants for the VGA DAC palette block:
//   - host register offsets (pel mask, read index / DAC state, write index, data)
//   - colour phase encoding for the shared R/G/B phase counter
//   - host FSM state encoding
//   - reset value of the pel mask and the DAC state codes returned on adr 1
// ---------------------------------------------------------------------------
package vga_dac_pkg;

    // Host register offsets
    localparam logic [1:0] ADR_PEL_MASK = 2'd0;
    localparam logic [1:0] ADR_RD_INDEX = 2'd1;
    localparam logic [1:0] ADR_WR_INDEX = 2'd2;
    localparam logic [1:0] ADR_DATA     = 2'd3;

    // Colour phase of the shared data-port counter
    localparam logic [1:0] PHASE_R = 2'd0;
    localparam logic [1:0] PHASE_G = 2'd1;
    localparam logic [1:0] PHASE_B = 2'd2;

    // Host FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK     = 2'd2;

    // Reset value of the pel mask: all index bits pass through
    localparam logic [7:0] PEL_MASK_RST = 8'hFF;

    // DAC state codes returned by a read of adr 1
    localparam logic [7:0] DAC_STATE_WRITE = 8'h00;
    localparam logic [7:0] DAC_STATE_READ  = 8'h03;

    // Width of one colour channel and of one palette entry
    localparam int CHAN_W  = 6;
    localparam int ENTRY_W = 3 * CHAN_W;

    // R -> G -> B -> R
    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        return (ph == PHASE_B) ? PHASE_R : ph + 2'd1;
    endfunction

endpackage

// File: rtl/vga_dac_palette_if.sv
// ---------------------------------------------------------------------------
// vga_dac_palette_if
// Host register bus of the VGA DAC palette.
//   host_stb   : one-cycle access strobe
//   host_we    : 1 = write, 0 = read (qualified by host_stb)
//   host_adr   : register offset (see vga_dac_pkg)
//   host_dat_i : write data
//   host_dat_o : read data, non-zero only while host_ack is high
//   host_ack   : one-cycle completion pulse
// master = the host driving accesses, slave = the DAC.
// ---------------------------------------------------------------------------
interface vga_dac_palette_if;

    logic       host_stb;
    logic       host_we;
    logic [1:0] host_adr;
    logic [7:0] host_dat_i;
    logic [7:0] host_dat_o;
    logic       host_ack;

    modport master (
        output host_stb,
        output host_we,
        output host_adr,
        output host_dat_i,
        input  host_dat_o,
        input  host_ack
    );

    modport slave (
        input  host_stb,
        input  host_we,
        input  host_adr,
        input  host_dat_i,
        output host_dat_o,
        output host_ack
    );

endinterface

// File: rtl/vga_dac_ram.sv
// ---------------------------------------------------------------------------
// vga_dac_ram
// 256 x 18 synchronous dual-port palette storage.
//   clk      : clock
//   a_addr   : pixel-side read address
//   a_q      : pixel-side read data, one clock after a_addr
//   b_addr   : host-side address (read or write)
//   b_we     : host-side write enable
//   b_wdata  : host-side write data {R,G,B}
//   b_q      : host-side read data, one clock after b_addr
// Both ports return the entry as it was before a write in the same cycle.
// Contents are never reset.
// ---------------------------------------------------------------------------
module vga_dac_ram
    import vga_dac_pkg::*;
(
    input  logic               clk,
    input  logic [7:0]         a_addr,
    output logic [ENTRY_W-1:0] a_q,
    input  logic [7:0]         b_addr,
    input  logic               b_we,
    input  logic [ENTRY_W-1:0] b_wdata,
    output logic [ENTRY_W-1:0] b_q
);

    logic [ENTRY_W-1:0] mem [256];

    // Reads and the write share one clocked block, so both read registers
    // capture the pre-write contents of the addressed entry.
    always_ff @(posedge clk) begin
        a_q <= mem[a_addr];
        b_q <= mem[b_addr];
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/vga_dac_palette.sv
// ---------------------------------------------------------------------------
// vga_dac_palette
// Palette DAC for a VGA pipeline: maps 8-bit pixel indices to 6:6:6 RGB via a
// 256-entry palette that the host programs through four byte registers.
//
// Ports
//   clk, rst          : clock, synchronous active-high reset
//   color             : palette index from the pixel fetcher
//   video_on_h_i      : display enable qualifying color
//   horiz_sync_i      : horizontal sync aligned with color
//   host              : host register bus (slave side)
//   vga_red_o/green/blue : DAC levels, 2 clocks after color
//   video_on_h_o, horiz_sync_o : enable/sync delayed to line up with RGB
//
// Host registers
//   0 : pel mask (R/W), ANDed into every pixel index
//   1 : write = set read index; read = DAC state (03 read mode, 00 write mode)
//   2 : write = set write index; read = current write index
//   3 : data, one colour channel per access in R, G, B order
// ---------------------------------------------------------------------------
module vga_dac_palette
    import vga_dac_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          color,
    input  logic                video_on_h_i,
    input  logic                horiz_sync_i,
    vga_dac_palette_if.slave    host,
    output logic [CHAN_W-1:0]   vga_red_o,
    output logic [CHAN_W-1:0]   vga_green_o,
    output logic [CHAN_W-1:0]   vga_blue_o,
    output logic                video_on_h_o,
    output logic                horiz_sync_o
);

    // Host-visible control state
    logic [7:0]        pel_mask;
    logic [7:0]        write_ptr;
    logic [7:0]        read_ptr;
    logic [1:0]        phase;
    logic              mode_read;
    logic [1:0]        state;
    logic [1:0]        rd_phase;
    logic [7:0]        dat_q;

    // Partial triplet collected over the R and G data writes
    logic [CHAN_W-1:0] red_lat;
    logic [CHAN_W-1:0] green_lat;

    // Pixel pipeline
    logic [7:0]         pix_addr_p0;
    logic [ENTRY_W-1:0] pal_q_p1;
    logic               vld_p1;
    logic               hs_p1;
    logic [ENTRY_W-1:0] rgb_p2;
    logic               vld_p2;
    logic               hs_p2;

    // Host RAM port
    logic               accept;
    logic               data_wr;
    logic               ram_we;
    logic [7:0]         ram_b_addr;
    logic [ENTRY_W-1:0] ram_b_wdata;
    logic [ENTRY_W-1:0] ram_b_q;

    // Pick one channel of a packed {R,G,B} entry.
    function automatic logic [CHAN_W-1:0] channel_sel(input logic [ENTRY_W-1:0] entry,
                                                      input logic [1:0]         ph);
        case (ph)
            PHASE_R: return entry[3*CHAN_W-1:2*CHAN_W];
            PHASE_G: return entry[2*CHAN_W-1:CHAN_W];
            default: return entry[CHAN_W-1:0];
        endcase
    endfunction

    // Force the DAC to black outside the active display area.
    function automatic logic [ENTRY_W-1:0] blank_rgb(input logic [ENTRY_W-1:0] entry,
                                                     input logic               vld);
        return vld ? entry : '0;
    endfunction

    // ---- stage 0 -> 1: palette lookup of the masked index ----
    assign pix_addr_p0 = color & pel_mask;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            hs_p1  <= 1'b0;
        end else begin
            vld_p1 <= video_on_h_i;
            hs_p1  <= horiz_sync_i;
        end
    end

    // ---- stage 1 -> 2: blanked RGB register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_p2 <= '0;
            vld_p2 <= 1'b0;
            hs_p2  <= 1'b0;
        end else begin
            rgb_p2 <= blank_rgb(pal_q_p1, vld_p1);
            vld_p2 <= vld_p1;
            hs_p2  <= hs_p1;
        end
    end

    assign vga_red_o    = rgb_p2[3*CHAN_W-1:2*CHAN_W];
    assign vga_green_o  = rgb_p2[2*CHAN_W-1:CHAN_W];
    assign vga_blue_o   = rgb_p2[CHAN_W-1:0];
    assign video_on_h_o = vld_p2;
    assign horiz_sync_o = hs_p2;

    // Host side: accesses are only taken in IDLE; strobes elsewhere are dropped.
    assign accept  = host.host_stb && (state == ST_IDLE);
    assign data_wr = accept && host.host_we && (host.host_adr == ADR_DATA);

    // The host port addresses the write pointer only on the committing B write;
    // otherwise it sits on read_ptr so a data read sees its entry next cycle.
    assign ram_we      = data_wr && (phase == PHASE_B);
    assign ram_b_addr  = ram_we ? write_ptr : read_ptr;
    assign ram_b_wdata = {red_lat, green_lat, host.host_dat_i[CHAN_W-1:0]};

    vga_dac_ram u_ram (
        .clk     (clk),
        .a_addr  (pix_addr_p0),
        .a_q     (pal_q_p1),
        .b_addr  (ram_b_addr),
        .b_we    (ram_we),
        .b_wdata (ram_b_wdata),
        .b_q     (ram_b_q)
    );

    // R and G are only held until the B write; an index write resets the
    // phase, so a stale partial triplet can never be committed.
    always_ff @(posedge clk) begin
        if (data_wr && (phase == PHASE_R)) begin
            red_lat <= host.host_dat_i[CHAN_W-1:0];
        end
        if (data_wr && (phase == PHASE_G)) begin
            green_lat <= host.host_dat_i[CHAN_W-1:0];
        end
    end

    // Host FSM and register file
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            pel_mask  <= PEL_MASK_RST;
            write_ptr <= 8'd0;
            read_ptr  <= 8'd0;
            phase     <= PHASE_R;
            mode_read <= 1'b0;
            rd_phase  <= PHASE_R;
            dat_q     <= 8'd0;
        end else begin
            // Read data is only non-zero during the ACK cycle.
            dat_q <= 8'd0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_ACK;
                        if (host.host_we) begin
                            case (host.host_adr)
                                ADR_PEL_MASK: pel_mask <= host.host_dat_i;
                                ADR_RD_INDEX: begin
                                    read_ptr  <= host.host_dat_i;
                                    phase     <= PHASE_R;
                                    mode_read <= 1'b1;
                                end
                                ADR_WR_INDEX: begin
                                    write_ptr <= host.host_dat_i;
                                    phase     <= PHASE_R;
                                    mode_read <= 1'b0;
                                end
                                default: begin
                                    if (phase == PHASE_B) begin
                                        write_ptr <= write_ptr + 8'd1;
                                    end
                                    phase <= next_phase(phase);
                                end
                            endcase
                        end else begin
                            case (host.host_adr)
                                ADR_PEL_MASK: dat_q <= pel_mask;
                                ADR_RD_INDEX: dat_q <= mode_read ? DAC_STATE_READ
                                                                 : DAC_STATE_WRITE;
                                ADR_WR_INDEX: dat_q <= write_ptr;
                                default: begin
                                    // RAM read of read_ptr is in flight; remember
                                    // which channel to return when it lands.
                                    state    <= ST_RD_WAIT;
                                    rd_phase <= phase;
                                    if (phase == PHASE_B) begin
                                        read_ptr <= read_ptr + 8'd1;
                                    end
                                    phase <= next_phase(phase);
                                end
                            endcase
                        end
                    end
                end
                ST_RD_WAIT: begin
                    dat_q <= {2'b00, channel_sel(ram_b_q, rd_phase)};
                    state <= ST_ACK;
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign host.host_ack   = (state == ST_ACK);
    assign host.host_dat_o = dat_q;

endmodule

// File: tb/tb_vga_dac_palette.sv
// ---------------------------------------------------------------------------
// tb_vga_dac_palette
// Directed testbench for vga_dac_palette: each scenario task drives its own
// stimulus and compares against hand-computed values.
// ---------------------------------------------------------------------------
module tb_vga_dac_palette;

    logic       clk;
    logic       rst;
    logic [7:0] color;
    logic       video_on_h_i;
    logic       horiz_sync_i;
    logic [5:0] vga_red_o;
    logic [5:0] vga_green_o;
    logic [5:0] vga_blue_o;
    logic       video_on_h_o;
    logic       horiz_sync_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int wr_bad = 0;

    vga_dac_palette_if bus ();

    vga_dac_palette dut (
        .clk          (clk),
        .rst          (rst),
        .color        (color),
        .video_on_h_i (video_on_h_i),
        .horiz_sync_i (horiz_sync_i),
        .host         (bus),
        .vga_red_o    (vga_red_o),
        .vga_green_o  (vga_green_o),
        .vga_blue_o   (vga_blue_o),
        .video_on_h_o (video_on_h_o),
        .horiz_sync_o (horiz_sync_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One host access; lat = clocks from strobe to ack (0 if no ack within 4).
    task automatic host_access(input logic we, input logic [1:0] adr, input logic [7:0] wd,
                               output logic [7:0] rd, output int lat);
        @(posedge clk); #1;
        bus.host_stb   = 1'b1;
        bus.host_we    = we;
        bus.host_adr   = adr;
        bus.host_dat_i = wd;
        lat = 0;
        rd  = 8'h00;
        for (int n = 1; n <= 4; n++) begin
            @(posedge clk); #1;
            bus.host_stb = 1'b0;
            if (bus.host_ack === 1'b1) begin
                rd  = bus.host_dat_o;
                lat = n;
                break;
            end
        end
    endtask

    // Register write; any write not acked exactly 1 clock later bumps wr_bad.
    task automatic wr(input logic [1:0] adr, input logic [7:0] d);
        logic [7:0] rd;
        int lat;
        host_access(1'b1, adr, d, rd, lat);
        if (lat != 1) wr_bad++;
    endtask

    task automatic wr_entry(input logic [7:0] idx, input logic [5:0] r, input logic [5:0] g,
                            input logic [5:0] b);
        wr(2'd2, idx);
        wr(2'd3, {2'b00, r});
        wr(2'd3, {2'b00, g});
        wr(2'd3, {2'b00, b});
    endtask

    // Present one displayed pixel and return the RGB seen 2 clocks later.
    task automatic pixel(input logic [7:0] c, output logic [17:0] rgb);
        @(posedge clk); #1;
        color        = c;
        video_on_h_i = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rgb          = {vga_red_o, vga_green_o, vga_blue_o};
        video_on_h_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] rd;
        int lat;
        rst = 1'b1;
        video_on_h_i = 1'b1;
        horiz_sync_i = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({vga_red_o, vga_green_o, vga_blue_o, video_on_h_o, horiz_sync_o,
             bus.host_ack, bus.host_dat_o} !== 29'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {vga_red_o, vga_green_o, vga_blue_o, video_on_h_o, horiz_sync_o,
                      bus.host_ack, bus.host_dat_o});
        end
        rst = 1'b0;
        video_on_h_i = 1'b0;
        horiz_sync_i = 1'b0;
        host_access(1'b0, 2'd0, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'hFF || lat != 1) begin
            n_fail++; $display("FAIL reset_pel_mask: got %h lat %0d required ff lat 1", rd, lat);
        end
        host_access(1'b0, 2'd1, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h00 || lat != 1) begin
            n_fail++; $display("FAIL reset_mode: got %h lat %0d required 00 lat 1", rd, lat);
        end
        host_access(1'b0, 2'd2, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h00 || lat != 1) begin
            n_fail++; $display("FAIL reset_write_ptr: got %h lat %0d required 00 lat 1", rd, lat);
        end
    endtask

    task automatic test_basic_write();
        logic [7:0] rd;
        int lat;
        wr_bad = 0;
        wr_entry(8'h10, 6'h3F, 6'h00, 6'h15);
        n_cmp++;
        if (wr_bad !== 0) begin
            n_fail++; $display("FAIL write_ack_latency: got %0d late acks required 0", wr_bad);
        end
        @(posedge clk); #1;
        color = 8'h10;
        video_on_h_i = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({vga_red_o, vga_green_o, vga_blue_o, video_on_h_o} !== 19'd0) begin
            n_fail++; $display("FAIL pixel_latency_early: got %h required 0",
                               {vga_red_o, vga_green_o, vga_blue_o, video_on_h_o});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({vga_red_o, vga_green_o, vga_blue_o, video_on_h_o} !== {6'h3F, 6'h00, 6'h15, 1'b1}) begin
            n_fail++; $display("FAIL pixel_entry10: got %h required %h",
                               {vga_red_o, vga_green_o, vga_blue_o, video_on_h_o},
                               {6'h3F, 6'h00, 6'h15, 1'b1});
        end
        video_on_h_i = 1'b0;
        host_access(1'b0, 2'd2, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h11) begin
            n_fail++; $display("FAIL write_ptr_incr: got %h required 11", rd);
        end
    endtask

    task automatic test_wrap();
        logic [7:0]  rd;
        logic [17:0] rgb;
        int lat;
        wr(2'd2, 8'hFF);
        wr(2'd3, 8'h01); wr(2'd3, 8'h02); wr(2'd3, 8'h03);
        wr(2'd3, 8'h04); wr(2'd3, 8'h05); wr(2'd3, 8'h06);
        host_access(1'b0, 2'd2, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h01) begin
            n_fail++; $display("FAIL write_ptr_wrap: got %h required 01", rd);
        end
        pixel(8'hFF, rgb);
        n_cmp++;
        if (rgb !== {6'h01, 6'h02, 6'h03}) begin
            n_fail++; $display("FAIL entry_ff: got %h required %h", rgb, {6'h01, 6'h02, 6'h03});
        end
        pixel(8'h00, rgb);
        n_cmp++;
        if (rgb !== {6'h04, 6'h05, 6'h06}) begin
            n_fail++; $display("FAIL entry_00: got %h required %h", rgb, {6'h04, 6'h05, 6'h06});
        end
    endtask

    task automatic test_pel_mask();
        logic [7:0]  rd;
        logic [17:0] rgb;
        int lat;
        wr_entry(8'h03, 6'h0A, 6'h0B, 6'h0C);
        wr_entry(8'hF3, 6'h11, 6'h22, 6'h33);
        wr(2'd0, 8'h0F);
        host_access(1'b0, 2'd0, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h0F) begin
            n_fail++; $display("FAIL pel_mask_read: got %h required 0f", rd);
        end
        pixel(8'hF3, rgb);
        n_cmp++;
        if (rgb !== {6'h0A, 6'h0B, 6'h0C}) begin
            n_fail++; $display("FAIL pel_mask_applied: got %h required %h", rgb, {6'h0A, 6'h0B, 6'h0C});
        end
        wr(2'd0, 8'hFF);
        pixel(8'hF3, rgb);
        n_cmp++;
        if (rgb !== {6'h11, 6'h22, 6'h33}) begin
            n_fail++; $display("FAIL pel_mask_open: got %h required %h", rgb, {6'h11, 6'h22, 6'h33});
        end
    endtask

    task automatic test_data_read();
        logic [7:0] rd;
        logic [7:0] exp_a [3];
        logic [7:0] exp_b [6];
        int lat;
        exp_a = '{8'h3F, 8'h00, 8'h15};
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        wr(2'd1, 8'h10);
        for (int i = 0; i < 3; i++) begin
            host_access(1'b0, 2'd3, 8'h00, rd, lat);
            n_cmp++;
            if (rd !== exp_a[i] || lat != 2) begin
                n_fail++; $display("FAIL data_read_%0d: got %h lat %0d required %h lat 2",
                                   i, rd, lat, exp_a[i]);
            end
        end
        host_access(1'b0, 2'd1, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h03) begin
            n_fail++; $display("FAIL dac_state_read: got %h required 03", rd);
        end
        wr(2'd1, 8'hFF);
        for (int i = 0; i < 6; i++) begin
            host_access(1'b0, 2'd3, 8'h00, rd, lat);
            n_cmp++;
            if (rd !== exp_b[i] || lat != 2) begin
                n_fail++; $display("FAIL read_ptr_wrap_%0d: got %h lat %0d required %h lat 2",
                                   i, rd, lat, exp_b[i]);
            end
        end
    endtask

    task automatic test_video_gate();
        logic [7:0]  v_pat;
        logic [7:0]  h_pat;
        logic [19:0] exp;
        v_pat = 8'b0011_1011;
        h_pat = 8'b0000_0110;
        @(posedge clk); #1;
        color = 8'h10;
        for (int i = 0; i <= 7; i++) begin
            video_on_h_i = v_pat[i];
            horiz_sync_i = h_pat[i];
            @(posedge clk); #1;
            if (i >= 1) begin
                exp = {v_pat[i-1] ? {6'h3F, 6'h00, 6'h15} : 18'd0, v_pat[i-1], h_pat[i-1]};
                n_cmp++;
                if ({vga_red_o, vga_green_o, vga_blue_o, video_on_h_o, horiz_sync_o} !== exp) begin
                    n_fail++; $display("FAIL video_gate_%0d: got %h required %h", i - 1,
                        {vga_red_o, vga_green_o, vga_blue_o, video_on_h_o, horiz_sync_o}, exp);
                end
            end
        end
        video_on_h_i = 1'b0;
        horiz_sync_i = 1'b0;
    endtask

    task automatic test_partial_triplet();
        logic [7:0]  rd;
        logic [17:0] rgb;
        int lat;
        wr_entry(8'h05, 6'h07, 6'h08, 6'h09);
        wr(2'd2, 8'h05);
        wr(2'd3, 8'h01);
        wr(2'd3, 8'h02);
        wr_entry(8'h06, 6'h0A, 6'h0B, 6'h0C);
        pixel(8'h05, rgb);
        n_cmp++;
        if (rgb !== {6'h07, 6'h08, 6'h09}) begin
            n_fail++; $display("FAIL partial_discard: got %h required %h", rgb, {6'h07, 6'h08, 6'h09});
        end
        pixel(8'h06, rgb);
        n_cmp++;
        if (rgb !== {6'h0A, 6'h0B, 6'h0C}) begin
            n_fail++; $display("FAIL after_partial: got %h required %h", rgb, {6'h0A, 6'h0B, 6'h0C});
        end
        host_access(1'b0, 2'd1, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'h00) begin
            n_fail++; $display("FAIL dac_state_write: got %h required 00", rd);
        end
    endtask

    task automatic test_read_before_write();
        wr_entry(8'h20, 6'h01, 6'h01, 6'h01);
        wr(2'd2, 8'h20);
        wr(2'd3, 8'h02);
        wr(2'd3, 8'h02);
        // B write commits on the same edge that the pixel port samples entry 20.
        @(posedge clk); #1;
        bus.host_stb   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_adr   = 2'd3;
        bus.host_dat_i = 8'h02;
        color          = 8'h20;
        video_on_h_i   = 1'b1;
        @(posedge clk); #1;
        bus.host_stb = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({vga_red_o, vga_green_o, vga_blue_o} !== {6'h01, 6'h01, 6'h01}) begin
            n_fail++; $display("FAIL rbw_old: got %h required %h",
                               {vga_red_o, vga_green_o, vga_blue_o}, {6'h01, 6'h01, 6'h01});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({vga_red_o, vga_green_o, vga_blue_o} !== {6'h02, 6'h02, 6'h02}) begin
            n_fail++; $display("FAIL rbw_new: got %h required %h",
                               {vga_red_o, vga_green_o, vga_blue_o}, {6'h02, 6'h02, 6'h02});
        end
        video_on_h_i = 1'b0;
    endtask

    task automatic test_busy_and_abort();
        logic [7:0]  rd;
        logic [17:0] rgb;
        int lat;
        int acks;
        wr(2'd1, 8'h10);
        // Data read, then a pel-mask write strobed while the read is in RD_WAIT.
        @(posedge clk); #1;
        bus.host_stb = 1'b1;
        bus.host_we  = 1'b0;
        bus.host_adr = 2'd3;
        @(posedge clk); #1;
        n_cmp++;
        if (bus.host_ack !== 1'b0 || bus.host_dat_o !== 8'h00) begin
            n_fail++; $display("FAIL rd_wait_idle_bus: got ack %b dat %h required 0/00",
                               bus.host_ack, bus.host_dat_o);
        end
        bus.host_we    = 1'b1;
        bus.host_adr   = 2'd0;
        bus.host_dat_i = 8'h55;
        @(posedge clk); #1;
        bus.host_stb = 1'b0;
        n_cmp++;
        if (bus.host_ack !== 1'b1 || bus.host_dat_o !== 8'h3F) begin
            n_fail++; $display("FAIL busy_read_ack: got ack %b dat %h required 1/3f",
                               bus.host_ack, bus.host_dat_o);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.host_ack !== 1'b0 || bus.host_dat_o !== 8'h00) begin
            n_fail++; $display("FAIL busy_no_extra_ack: got ack %b dat %h required 0/00",
                               bus.host_ack, bus.host_dat_o);
        end
        host_access(1'b0, 2'd0, 8'h00, rd, lat);
        n_cmp++;
        if (rd !== 8'hFF) begin
            n_fail++; $display("FAIL busy_strobe_ignored: got %h required ff", rd);
        end
        // Reset while the data read waits in RD_WAIT: no ack may follow.
        @(posedge clk); #1;
        bus.host_stb = 1'b1;
        bus.host_we  = 1'b0;
        bus.host_adr = 2'd3;
        @(posedge clk); #1;
        bus.host_stb = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acks = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.host_ack !== 1'b0) acks++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (acks !== 0) begin
            n_fail++; $display("FAIL abort_no_ack: got %0d acks required 0", acks);
        end
        pixel(8'h10, rgb);
        n_cmp++;
        if (rgb !== {6'h3F, 6'h00, 6'h15}) begin
            n_fail++; $display("FAIL palette_kept: got %h required %h", rgb, {6'h3F, 6'h00, 6'h15});
        end
    endtask

    initial begin
        rst            = 1'b1;
        color          = 8'h00;
        video_on_h_i   = 1'b0;
        horiz_sync_i   = 1'b0;
        bus.host_stb   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_adr   = 2'd0;
        bus.host_dat_i = 8'h00;
        test_reset();
        test_basic_write();
        test_wrap();
        test_pel_mask();
        test_data_read();
        test_video_gate();
        test_partial_triplet();
        test_read_before_write();
        test_busy_and_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got stalled required completion");
        $fatal(1, "timeout");
    end

endmodule
